// File: rtl/skew_pkg.sv
// Shared types and sizing helpers for the skew loader slice.
// Optional feature macro used by this slice: SKEW_LOADER_DOUBLE_BUF_EN.
package skew_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  localparam int DATA_BITS_DEF   = 8;
  localparam int MATRIX_SIZE_DEF = 8;

  // Number of skewed slots per lane: column k of lane i lands at slot i+k.
  function automatic int out_size(input int n);
    return 2 * n - 1;
  endfunction

  localparam int OUTPUT_SIZE_DEF = out_size(MATRIX_SIZE_DEF);

  typedef logic [0:MATRIX_SIZE_DEF-1][DATA_BITS_DEF-1:0] col_t;
  typedef logic [0:MATRIX_SIZE_DEF-1][0:OUTPUT_SIZE_DEF-1][DATA_BITS_DEF-1:0] image_t;

endpackage

// File: rtl/skew_loader_if.sv
// Column-in / image-out handshake bundle of the skew loader.
interface skew_loader_if #(
  parameter int DATA_BITS   = 8,
  parameter int MATRIX_SIZE = 8,
  parameter int OUTPUT_SIZE = 2 * MATRIX_SIZE - 1
);
  // Both channels are strict valid/ready: a transfer happens on a rising clock edge
  // where valid and ready are both high; valid, once raised, holds with stable data
  // until that transfer; ready may be driven independently of valid.
  logic                                              in_valid;
  logic                                              in_ready;
  logic [0:MATRIX_SIZE-1][DATA_BITS-1:0]             in_col;
  logic                                              out_valid;
  logic                                              out_ready;
  logic [0:MATRIX_SIZE-1][0:OUTPUT_SIZE-1][DATA_BITS-1:0] data_out;

  modport master (
    output in_valid, in_col, out_ready,
    input  in_ready, out_valid, data_out
  );

  modport slave (
    input  in_valid, in_col, out_ready,
    output in_ready, out_valid, data_out
  );
endinterface

// File: rtl/skew_bank.sv
// One skewed image bank: each write drops a column onto its diagonal, clear zeroes all slots.
module skew_bank
  import skew_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int MATRIX_SIZE = 8,
  parameter int OUTPUT_SIZE = out_size(MATRIX_SIZE)
) (
  input  logic                                              clock,
  input  logic                                              reset,
  input  logic                                              clear,
  input  logic                                              write_en,
  input  logic [$clog2(MATRIX_SIZE+1)-1:0]                  col_idx,
  input  logic [0:MATRIX_SIZE-1][DATA_BITS-1:0]             in_col,
  output logic [0:MATRIX_SIZE-1][0:OUTPUT_SIZE-1][DATA_BITS-1:0] image
);

  // Slots off the diagonal band are only ever written by reset/clear, so they stay 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      image <= '0;
    end else if (clear) begin
      image <= '0;
    end else if (write_en) begin
      for (int i = 0; i < MATRIX_SIZE; i++) begin
        for (int j = 0; j < OUTPUT_SIZE; j++) begin
          if (j == i + int'(col_idx)) begin
            image[i][j] <= in_col[i];
          end
        end
      end
    end
  end

endmodule

// File: rtl/skew_loader.sv
// Builds the diagonally skewed image for the systolic shift register, one column per beat.
// Define SKEW_LOADER_DOUBLE_BUF_EN for two ping-pong banks (no bubble between matrices).
module skew_loader
  import skew_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int MATRIX_SIZE = 8,
  parameter int OUTPUT_SIZE = out_size(MATRIX_SIZE)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               flush,
  skew_loader_if.slave                       bus,
  output logic [$clog2(MATRIX_SIZE+1)-1:0]   col_count,
  output state_t                             fsm_state
);

  localparam int CW = $clog2(MATRIX_SIZE + 1);
  localparam logic [CW-1:0] LAST_COL = CW'(MATRIX_SIZE - 1);
  localparam logic [CW-1:0] ALL_COLS = CW'(MATRIX_SIZE);

  if (OUTPUT_SIZE != out_size(MATRIX_SIZE)) begin : g_size_check
    $error("skew_loader: OUTPUT_SIZE must equal 2*MATRIX_SIZE-1");
  end

  logic in_ready_q;
  logic out_valid_q;
  logic accept;
  logic handshake;

  // flush wins over any same-cycle beat or image handoff.
  assign accept    = bus.in_valid & in_ready_q & ~flush;
  assign handshake = out_valid_q & bus.out_ready & ~flush;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;

`ifdef SKEW_LOADER_DOUBLE_BUF_EN

  logic [0:1][0:MATRIX_SIZE-1][0:OUTPUT_SIZE-1][DATA_BITS-1:0] images;
  logic [1:0]    bank_full;
  logic [1:0]    bank_full_n;
  logic          fill_ptr;
  logic          fill_ptr_n;
  logic          out_ptr;
  logic          out_ptr_n;
  logic          last_accept;
  logic [CW-1:0] count_n;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    skew_bank #(
      .DATA_BITS   (DATA_BITS),
      .MATRIX_SIZE (MATRIX_SIZE),
      .OUTPUT_SIZE (OUTPUT_SIZE)
    ) u_bank (
      .clock    (clock),
      .reset    (reset),
      .clear    (flush | (handshake & (out_ptr == 1'(b)))),
      .write_en (accept & (fill_ptr == 1'(b))),
      .col_idx  (col_count),
      .in_col   (bus.in_col),
      .image    (images[b])
    );
  end

  assign last_accept = accept & (col_count == LAST_COL);

  // The fill pointer leads the output pointer by the number of held banks, so when
  // nothing is held both point at the same bank and data_out shows the partial fill.
  always_comb begin
    bank_full_n = bank_full;
    fill_ptr_n  = fill_ptr;
    out_ptr_n   = out_ptr;
    count_n     = col_count;
    if (handshake) begin
      bank_full_n[out_ptr] = 1'b0;
      out_ptr_n            = ~out_ptr;
    end
    if (last_accept) begin
      bank_full_n[fill_ptr] = 1'b1;
      fill_ptr_n            = ~fill_ptr;
    end
    if (bank_full_n[fill_ptr_n]) begin
      count_n = ALL_COLS;
    end else if (last_accept || (handshake && (out_ptr == fill_ptr))) begin
      count_n = '0;
    end else if (accept) begin
      count_n = col_count + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bank_full   <= '0;
      fill_ptr    <= 1'b0;
      out_ptr     <= 1'b0;
      col_count   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      fsm_state   <= FILL;
    end else if (flush) begin
      bank_full   <= '0;
      fill_ptr    <= 1'b0;
      out_ptr     <= 1'b0;
      col_count   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      fsm_state   <= FILL;
    end else begin
      bank_full   <= bank_full_n;
      fill_ptr    <= fill_ptr_n;
      out_ptr     <= out_ptr_n;
      col_count   <= count_n;
      in_ready_q  <= ~bank_full_n[fill_ptr_n];
      out_valid_q <= bank_full_n[out_ptr_n];
      fsm_state   <= bank_full_n[fill_ptr_n] ? FULL : FILL;
    end
  end

  assign bus.data_out = images[out_ptr];

`else

  logic [0:MATRIX_SIZE-1][0:OUTPUT_SIZE-1][DATA_BITS-1:0] image;

  skew_bank #(
    .DATA_BITS   (DATA_BITS),
    .MATRIX_SIZE (MATRIX_SIZE),
    .OUTPUT_SIZE (OUTPUT_SIZE)
  ) u_bank (
    .clock    (clock),
    .reset    (reset),
    .clear    (flush | handshake),
    .write_en (accept),
    .col_idx  (col_count),
    .in_col   (bus.in_col),
    .image    (image)
  );

  // The handoff cycle itself is the single bubble: in_ready is still low while FULL.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm_state   <= FILL;
      col_count   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      fsm_state   <= FILL;
      col_count   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (fsm_state)
        FILL: begin
          if (accept) begin
            col_count <= col_count + CW'(1);
            if (col_count == LAST_COL) begin
              fsm_state   <= FULL;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        FULL: begin
          if (handshake) begin
            fsm_state   <= FILL;
            col_count   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          fsm_state <= FILL;
        end
      endcase
    end
  end

  assign bus.data_out = image;

`endif

endmodule

// File: tb/tb_skew_loader.sv
// Self-checking bench for skew_loader: directed steps plus random traffic against a queue model.
module tb_skew_loader;
  import skew_pkg::*;

  localparam int M = 8;
  localparam int O = 15;
`ifdef SKEW_LOADER_DOUBLE_BUF_EN
  localparam int MAX_HELD = 2;
`else
  localparam int MAX_HELD = 1;
`endif

  logic       clock;
  logic       reset;
  logic       flush;
  logic [3:0] col_count;
  state_t     fsm_state;

  skew_loader_if #(.DATA_BITS(8), .MATRIX_SIZE(M), .OUTPUT_SIZE(O)) bus ();

  skew_loader #(.DATA_BITS(8), .MATRIX_SIZE(M), .OUTPUT_SIZE(O)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus),
    .col_count (col_count),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // reference model: partial matrix as a column list, completed images in a queue
  col_t   cur_q[$];
  image_t done_q[$];

  function automatic image_t skew(input col_t cols[$]);
    image_t img = '0;
    for (int k = 0; k < cols.size(); k++)
      for (int i = 0; i < M; i++)
        img[i][i+k] = cols[k][i];
    return img;
  endfunction

  function automatic logic exp_in_ready();
    return done_q.size() < MAX_HELD;
  endfunction

  function automatic logic exp_out_valid();
    return done_q.size() > 0;
  endfunction

  function automatic logic [3:0] exp_col_count();
    return (done_q.size() == MAX_HELD) ? 4'(M) : 4'(cur_q.size());
  endfunction

  function automatic image_t exp_data();
    return (done_q.size() > 0) ? done_q[0] : skew(cur_q);
  endfunction

  function automatic col_t ramp_col(input int k);
    col_t c;
    for (int i = 0; i < M; i++) c[i] = 8'(i * 8 + k);
    return c;
  endfunction

  function automatic col_t const_col(input logic [7:0] v);
    col_t c;
    for (int i = 0; i < M; i++) c[i] = v;
    return c;
  endfunction

  function automatic col_t rand_col();
    col_t c;
    for (int i = 0; i < M; i++) c[i] = 8'($urandom_range(0, 255));
    return c;
  endfunction

  // scoreboard compare
  task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".in_ready"},  1024'(bus.in_ready),  1024'(exp_in_ready()));
    check({tag, ".out_valid"}, 1024'(bus.out_valid), 1024'(exp_out_valid()));
    check({tag, ".col_count"}, 1024'(col_count),     1024'(exp_col_count()));
    check({tag, ".state"},     1024'(fsm_state),     1024'(exp_in_ready() ? FILL : FULL));
    check({tag, ".data_out"},  1024'(bus.data_out),  1024'(exp_data()));
  endtask

  // driver: one clock of stimulus, model update at the edge, sample 1ns later
  task automatic cycle(input string tag, input logic v, input col_t c,
                       input logic ordy, input logic fl);
    logic acc;
    logic hs;
    bus.in_valid  = v;
    bus.in_col    = c;
    bus.out_ready = ordy;
    flush         = fl;
    acc = v && exp_in_ready() && !fl;
    hs  = exp_out_valid() && ordy && !fl;
    @(posedge clock);
    if (fl) begin
      cur_q.delete();
      done_q.delete();
    end else begin
      if (hs) void'(done_q.pop_front());
      if (acc) begin
        cur_q.push_back(c);
        if (cur_q.size() == M) begin
          done_q.push_back(skew(cur_q));
          cur_q.delete();
        end
      end
    end
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input string tag, input logic ordy);
    cycle(tag, 1'b0, '0, ordy, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 1024'(bus.data_out), 1024'(0));
  endtask

  task automatic check_ramp_slots(input string tag);
    check({tag, ".slot_3_5"}, 1024'(bus.data_out[3][5]), 1024'(26));
    for (int j = 8; j < O; j++)
      check($sformatf("%s.lane0_slot%0d", tag, j), 1024'(bus.data_out[0][j]), 1024'(0));
    for (int j = 0; j < 7; j++)
      check($sformatf("%s.lane7_slot%0d", tag, j), 1024'(bus.data_out[7][j]), 1024'(0));
  endtask

  initial begin
    int k;
    reset         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_col    = '0;
    bus.out_ready = 1'b0;
    #10 reset = 1'b1;
    #20 reset = 1'b0;

    check("reset.out_valid", 1024'(bus.out_valid), 1024'(0));
    check("reset.in_ready",  1024'(bus.in_ready),  1024'(1));
    check("reset.col_count", 1024'(col_count),     1024'(0));
    check_all_zero("reset.data_out");

    // straight fill, image held with out_ready low
    for (int n = 0; n < M; n++) cycle("fill", 1'b1, ramp_col(n), 1'b0, 1'b0);
    check("fill.out_valid", 1024'(bus.out_valid), 1024'(1));
    check_ramp_slots("fill");
`ifndef SKEW_LOADER_DOUBLE_BUF_EN
    check("fill.in_ready", 1024'(bus.in_ready), 1024'(0));
`endif
    for (int n = 0; n < 3; n++) idle("hold1", 1'b0);
    idle("handoff1", 1'b1);
    check_all_zero("handoff1.data_out");

    // backpressure on the input side: valid every other cycle
    k = 0;
    for (int n = 0; n < 2 * M; n++) begin
      if (n % 2 == 0) begin
        cycle("bp", 1'b1, ramp_col(k), 1'b0, 1'b0);
        k++;
      end else begin
        cycle("bp", 1'b0, ramp_col(k), 1'b0, 1'b0);
      end
    end
    check_ramp_slots("bp");
    for (int n = 0; n < 20; n++) idle("bp_hold", 1'b0);
    idle("handoff2", 1'b1);
    check("handoff2.out_valid", 1024'(bus.out_valid), 1024'(0));
    check("handoff2.col_count", 1024'(col_count), 1024'(0));
    check_all_zero("handoff2.data_out");

    // all-ones matrix
    for (int n = 0; n < M; n++) cycle("ff", 1'b1, const_col(8'hFF), 1'b0, 1'b0);
    for (int j = 2; j <= 9; j++)
      check($sformatf("ff.lane2_slot%0d", j), 1024'(bus.data_out[2][j]), 1024'(8'hFF));
    check("ff.lane2_slot1",  1024'(bus.data_out[2][1]),  1024'(0));
    check("ff.lane2_slot10", 1024'(bus.data_out[2][10]), 1024'(0));
    idle("handoff3", 1'b1);

    // flush after 4 beats drops the concurrent beat
    for (int n = 0; n < 4; n++) cycle("pre_flush", 1'b1, ramp_col(n), 1'b0, 1'b0);
    cycle("flush", 1'b1, ramp_col(4), 1'b0, 1'b1);
    check("flush.col_count", 1024'(col_count), 1024'(0));
    check_all_zero("flush.data_out");
    for (int n = 0; n < M; n++) cycle("post_flush", 1'b1, ramp_col(n), 1'b0, 1'b0);
    check_ramp_slots("post_flush");
    idle("handoff4", 1'b1);

    // asynchronous reset in the middle of a fill
    for (int n = 0; n < 3; n++) cycle("pre_reset", 1'b1, rand_col(), 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("areset.in_ready",  1024'(bus.in_ready),  1024'(1));
    check("areset.out_valid", 1024'(bus.out_valid), 1024'(0));
    check("areset.col_count", 1024'(col_count),     1024'(0));
    check_all_zero("areset.data_out");
    #1 reset = 1'b0;
    cur_q.delete();
    done_q.delete();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      cycle("rand", 1'($urandom_range(0, 3) != 0), rand_col(),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 59) == 0));
    end
    cycle("drain_flush", 1'b0, '0, 1'b0, 1'b1);

`ifdef SKEW_LOADER_DOUBLE_BUF_EN
    // streaming: in_ready must never drop, a matrix leaves every 8 cycles
    for (int n = 0; n < 10 * M; n++) begin
      cycle("stream", 1'b1, rand_col(), 1'b1, 1'b0);
      check("stream.in_ready_high", 1024'(bus.in_ready), 1024'(1));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
